branch_resolve_unit: RTL and testbench
======================================

Name: branch_resolve_unit

Overview:
- Execute-stage counterpart of the fetch-side branch predictor (BTB + 2-bit BHT).
- Holds an in-order queue of in-flight predictions pushed by fetch.
- On each execute-stage branch resolution, pops the oldest prediction, compares it with the actual outcome, and drives the predictor update bus.
- On a mispredict, issues a one-cycle redirect/flush to fetch and keeps hit/miss statistics.

Parameters:
- ADDR_WIDTH, 32, PC/target width
- DEPTH, 8, in-flight prediction queue entries (power of 2)
- PTR_BITS, 3, log2(DEPTH)
- CNT_WIDTH, 16, statistics counter width

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- push_valid  in  1  fetch issues a branch prediction record
- push_ready  out  1  queue can accept a record
- push_pc  in  ADDR_WIDTH  PC of the fetched branch
- push_pred_taken  in  1  predicted direction
- push_pred_target  in  ADDR_WIDTH  predicted target (don't-care if not taken)
- resolve_valid  in  1  execute resolves the oldest branch this cycle
- resolve_taken  in  1  actual direction
- resolve_target  in  ADDR_WIDTH  actual taken target
- flush  in  1  external pipeline flush (exception/interrupt); discards queue
- upd_valid  out  1  predictor update strobe
- upd_pc  out  ADDR_WIDTH  branch PC
- upd_target  out  ADDR_WIDTH  actual target
- upd_taken  out  1  actual outcome
- upd_is_branch  out  1  always 1 when upd_valid, else 0
- redirect_valid  out  1  mispredict redirect pulse to fetch
- redirect_pc  out  ADDR_WIDTH  correct next PC
- resolve_err  out  1  pulse: resolve arrived with queue empty
- branch_count  out  CNT_WIDTH  resolved branches, saturating
- mispredict_count  out  CNT_WIDTH  mispredicts, saturating

Behaviour:
- Reset: queue empty, pointers 0, occupancy 0, push_ready=0 while reset high. All registered outputs 0, both counters 0.
- push_ready = !full, combinational, with no same-cycle bypass from pop. A full queue refuses a push even if a resolve pops that cycle.
- Push: record {pc, pred_taken, pred_target} is written at the tail on the edge where push_valid && push_ready. The tail pointer wraps modulo DEPTH.
- Resolve with queue non-empty:
  - Pop the head.
  - mispredict = (pred_taken != resolve_taken) || (resolve_taken && pred_target != resolve_target).
- Update bus, registered, 1-cycle latency after resolve:
  - upd_valid=1, upd_is_branch=1
  - upd_pc = head pc
  - upd_taken = resolve_taken
  - upd_target = resolve_target if taken, else head pred_target
- Redirect, registered on the same cycle as the update:
  - redirect_valid = mispredict.
  - redirect_pc = resolve_target if taken, else head pc + 4 (mod 2^ADDR_WIDTH, wraps).
- Mispredict flush: at the resolve edge, the whole queue is cleared (younger entries are wrong-path). A push in the same cycle is dropped.
- External flush: clears the queue at the edge and produces no update or redirect.
  - flush together with resolve: the resolve is still processed (update and redirect issued), then the queue ends empty.
  - flush together with push: the push is dropped.
- Resolve with queue empty: no update, no redirect, no counter change; resolve_err pulses 1 for one cycle.
- Counters: branch_count +1 per non-error resolve; mispredict_count +1 per mispredict. Both saturate at all-ones.
- Simultaneous push and resolve (queue not full, no mispredict): both occur and occupancy is unchanged.
- Pulses: upd_valid, redirect_valid and resolve_err are single-cycle. They are 0 in any cycle following no resolve.
- Reset mid-operation discards all entries and pending outputs. Outputs are 0 on the cycle after reset is sampled.

Decomposition:
- Shared package bpu_pkg:
  - pred_rec_t struct {pc, pred_taken, pred_target}
  - mispredict-compare function
  - PC_INCR=4 constant
- Sub-module branch_pred_fifo: DEPTH-entry synchronous FIFO of pred_rec_t with push/pop/clear, full/empty and occupancy. branch_resolve_unit instantiates it and adds the compare, update, redirect and counter logic.

Test Plan:
- Correct not-taken: push {pc=0x100, pred_taken=0}, resolve taken=0 -> next cycle upd_valid=1, upd_pc=0x100, upd_taken=0, redirect_valid=0, branch_count=1.
- Direction mispredict: push {0x200, pred_taken=0}, push {0x204,...}, resolve taken=1, target=0x400 -> redirect_valid=1, redirect_pc=0x400, mispredict_count=1, queue empty afterwards (push_ready=1, next resolve gives resolve_err=1).
- Target mispredict: push {0x300, 1, 0x500}, resolve taken=1, target=0x600 -> redirect_pc=0x600, upd_target=0x600. Predicted-taken resolved not-taken -> redirect_pc=0x304.
- Full and wrap: push 8 records -> push_ready=0, a 9th push is ignored. Resolve all 8 correctly -> PCs emerge in order. Push 3 more -> wrap-around order is preserved.
- Empty resolve and flush: resolve on an empty queue -> resolve_err=1, counters unchanged. Assert flush with 4 entries -> no upd_valid, queue empty.
- Saturation and reset: with CNT_WIDTH=4, 20 mispredicts -> both counters hold 0xF. Reset mid-stream -> all outputs 0 and push_ready=0 during reset.

Source files
------------

// File: rtl/bpu_pkg.sv
// Shared types and helpers for the branch prediction/resolution path.
// Prediction records are sized by BPU_ADDR_WIDTH, so units using them keep ADDR_WIDTH equal to it.
package bpu_pkg;

    localparam int unsigned BPU_ADDR_WIDTH = 32;
    localparam int unsigned PC_INCR        = 4;

    typedef struct packed {
        logic [BPU_ADDR_WIDTH-1:0] pc;
        logic                      pred_taken;
        logic [BPU_ADDR_WIDTH-1:0] pred_target;
    } pred_rec_t;

    // A taken branch is only correct when the predicted target also matches.
    function automatic logic bpu_mispredict(
        input pred_rec_t                 rec,
        input logic                      taken,
        input logic [BPU_ADDR_WIDTH-1:0] target
    );
        return (rec.pred_taken != taken) || (taken && (rec.pred_target != target));
    endfunction

endpackage

// File: rtl/branch_pred_fifo.sv
// In-order queue of in-flight branch predictions with push/pop/clear.
// The head entry is presented combinationally; clear has priority over push and pop.
module branch_pred_fifo
    import bpu_pkg::*;
#(
    parameter int unsigned DEPTH    = 8,
    parameter int unsigned PTR_BITS = 3
) (
    input  logic      clk,
    input  logic      reset,
    input  logic      clear,
    input  logic      push,
    input  logic      pop,
    input  pred_rec_t push_data,
    output pred_rec_t head,
    output logic      full,
    output logic      empty
);

    pred_rec_t             mem [DEPTH];
    logic [PTR_BITS-1:0]   rd_ptr;
    logic [PTR_BITS-1:0]   wr_ptr;
    logic [PTR_BITS:0]     count;
    logic                  do_push;
    logic                  do_pop;

    assign full    = (count == (PTR_BITS+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_BITS'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_BITS'(1);
            end
            count <= count + (PTR_BITS+1)'(do_push) - (PTR_BITS+1)'(do_pop);
        end
    end

endmodule

// File: rtl/branch_resolve_unit.sv
// Execute-stage branch resolution: checks the oldest in-flight prediction against the
// actual outcome, drives the predictor update bus, redirects fetch on mispredict and keeps stats.
module branch_resolve_unit
    import bpu_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DEPTH      = 8,
    parameter int unsigned PTR_BITS   = 3,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push_valid,
    output logic                  push_ready,
    input  logic [ADDR_WIDTH-1:0] push_pc,
    input  logic                  push_pred_taken,
    input  logic [ADDR_WIDTH-1:0] push_pred_target,
    input  logic                  resolve_valid,
    input  logic                  resolve_taken,
    input  logic [ADDR_WIDTH-1:0] resolve_target,
    input  logic                  flush,
    output logic                  upd_valid,
    output logic [ADDR_WIDTH-1:0] upd_pc,
    output logic [ADDR_WIDTH-1:0] upd_target,
    output logic                  upd_taken,
    output logic                  upd_is_branch,
    output logic                  redirect_valid,
    output logic [ADDR_WIDTH-1:0] redirect_pc,
    output logic                  resolve_err,
    output logic [CNT_WIDTH-1:0]  branch_count,
    output logic [CNT_WIDTH-1:0]  mispredict_count
);

    pred_rec_t push_rec;
    pred_rec_t head;
    logic      full;
    logic      empty;
    logic      resolve_fire;
    logic      mispredict;
    logic      push_fire;
    logic      clear_queue;

    assign push_ready   = !reset && !full;
    assign resolve_fire = resolve_valid && !empty;
    assign mispredict   = resolve_fire && bpu_mispredict(head, resolve_taken, resolve_target);
    // Younger entries behind a mispredict are wrong-path, so a same-cycle push is dropped too.
    assign clear_queue  = flush || mispredict;
    assign push_fire    = push_valid && push_ready && !clear_queue;

    assign push_rec.pc          = push_pc;
    assign push_rec.pred_taken  = push_pred_taken;
    assign push_rec.pred_target = push_pred_target;

    branch_pred_fifo #(
        .DEPTH    (DEPTH),
        .PTR_BITS (PTR_BITS)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .clear     (clear_queue),
        .push      (push_fire),
        .pop       (resolve_fire),
        .push_data (push_rec),
        .head      (head),
        .full      (full),
        .empty     (empty)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            upd_valid        <= 1'b0;
            upd_is_branch    <= 1'b0;
            upd_pc           <= '0;
            upd_target       <= '0;
            upd_taken        <= 1'b0;
            redirect_valid   <= 1'b0;
            redirect_pc      <= '0;
            resolve_err      <= 1'b0;
            branch_count     <= '0;
            mispredict_count <= '0;
        end else begin
            upd_valid      <= resolve_fire;
            upd_is_branch  <= resolve_fire;
            redirect_valid <= mispredict;
            resolve_err    <= resolve_valid && empty;
            if (resolve_fire) begin
                upd_pc      <= head.pc;
                upd_taken   <= resolve_taken;
                upd_target  <= resolve_taken ? resolve_target : head.pred_target;
                redirect_pc <= resolve_taken ? resolve_target
                                             : head.pc + ADDR_WIDTH'(PC_INCR);
                if (branch_count != '1) begin
                    branch_count <= branch_count + CNT_WIDTH'(1);
                end
                if (mispredict && (mispredict_count != '1)) begin
                    mispredict_count <= mispredict_count + CNT_WIDTH'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed scoreboard bench for branch_resolve_unit (CNT_WIDTH=4 to reach saturation quickly).
module tb_branch_resolve_unit;

    localparam int unsigned AW = 32;
    localparam int unsigned CW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          push_valid;
    logic          push_ready;
    logic [AW-1:0] push_pc;
    logic          push_pred_taken;
    logic [AW-1:0] push_pred_target;
    logic          resolve_valid;
    logic          resolve_taken;
    logic [AW-1:0] resolve_target;
    logic          flush;
    logic          upd_valid;
    logic [AW-1:0] upd_pc;
    logic [AW-1:0] upd_target;
    logic          upd_taken;
    logic          upd_is_branch;
    logic          redirect_valid;
    logic [AW-1:0] redirect_pc;
    logic          resolve_err;
    logic [CW-1:0] branch_count;
    logic [CW-1:0] mispredict_count;

    always #5 clk = ~clk;

    branch_resolve_unit #(
        .ADDR_WIDTH (AW),
        .DEPTH      (8),
        .PTR_BITS   (3),
        .CNT_WIDTH  (CW)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .push_valid       (push_valid),
        .push_ready       (push_ready),
        .push_pc          (push_pc),
        .push_pred_taken  (push_pred_taken),
        .push_pred_target (push_pred_target),
        .resolve_valid    (resolve_valid),
        .resolve_taken    (resolve_taken),
        .resolve_target   (resolve_target),
        .flush            (flush),
        .upd_valid        (upd_valid),
        .upd_pc           (upd_pc),
        .upd_target       (upd_target),
        .upd_taken        (upd_taken),
        .upd_is_branch    (upd_is_branch),
        .redirect_valid   (redirect_valid),
        .redirect_pc      (redirect_pc),
        .resolve_err      (resolve_err),
        .branch_count     (branch_count),
        .mispredict_count (mispredict_count)
    );

    typedef struct {
        logic [AW-1:0] pc;
        logic          taken;
        logic [AW-1:0] tgt;
    } rec_t;

    typedef struct {
        bit            err;
        logic [AW-1:0] pc;
        logic          taken;
        logic [AW-1:0] tgt;
        bit            redir;
        logic [AW-1:0] rpc;
    } exp_t;

    rec_t model[$];
    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    int   bc = 0;
    int   mc = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Outputs are registered; sample 1 time unit after the edge, inputs change on negedges.
    always @(posedge clk) begin
        #1;
        if (!reset) begin
            if (upd_valid || resolve_err || redirect_valid) begin
                if (sb.size() == 0) begin
                    chk("unexpected_output", {29'b0, upd_valid, resolve_err, redirect_valid}, 32'd0);
                end else begin
                    mon_e = sb.pop_front();
                    chk("resolve_err", resolve_err, mon_e.err);
                    chk("upd_valid", upd_valid, !mon_e.err);
                    chk("upd_is_branch", upd_is_branch, !mon_e.err);
                    chk("redirect_valid", redirect_valid, mon_e.redir);
                    if (!mon_e.err) begin
                        chk("upd_pc", upd_pc, mon_e.pc);
                        chk("upd_taken", upd_taken, mon_e.taken);
                        chk("upd_target", upd_target, mon_e.tgt);
                        chk("redirect_pc", redirect_pc, mon_e.rpc);
                    end
                end
            end else if (sb.size() != 0) begin
                void'(sb.pop_front());
                chk("missing_output", 32'd0, 32'd1);
            end
        end
    end

    // One cycle of stimulus, applied just after a negedge; the model follows the intended behaviour.
    task automatic do_cycle(input bit pv, input logic [AW-1:0] ppc, input bit pt,
                            input logic [AW-1:0] ptgt, input bit rv, input bit rt,
                            input logic [AW-1:0] rtgt, input bit fl);
        int   occ;
        bit   mis;
        rec_t h;
        push_valid       = pv;
        push_pc          = ppc;
        push_pred_taken  = pt;
        push_pred_target = ptgt;
        resolve_valid    = rv;
        resolve_taken    = rt;
        resolve_target   = rtgt;
        flush            = fl;
        #1;
        occ = model.size();
        chk("push_ready", push_ready, occ < 8);
        chk("branch_count", branch_count, bc);
        chk("mispredict_count", mispredict_count, mc);
        mis = 1'b0;
        if (rv) begin
            if (occ == 0) begin
                sb.push_back('{1'b1, '0, 1'b0, '0, 1'b0, '0});
            end else begin
                h   = model.pop_front();
                mis = (h.taken != rt) || (rt && (h.tgt != rtgt));
                sb.push_back('{1'b0, h.pc, rt, (rt ? rtgt : h.tgt), mis,
                               (rt ? rtgt : h.pc + 32'd4)});
                if (bc < 15) bc++;
                if (mis && mc < 15) mc++;
            end
        end
        if (mis || fl) begin
            model.delete();
        end else if (pv && occ < 8) begin
            model.push_back('{ppc, pt, ptgt});
        end
        @(negedge clk);
    endtask

    task automatic push(input logic [AW-1:0] pc, input bit pt, input logic [AW-1:0] tgt);
        do_cycle(1'b1, pc, pt, tgt, 1'b0, 1'b0, '0, 1'b0);
    endtask

    task automatic resolve(input bit t, input logic [AW-1:0] tgt);
        do_cycle(1'b0, '0, 1'b0, '0, 1'b1, t, tgt, 1'b0);
    endtask

    task automatic idle();
        do_cycle(1'b0, '0, 1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
    endtask

    task automatic check_reset_state();
        chk("rst_push_ready", push_ready, 32'd0);
        chk("rst_upd_valid", upd_valid, 32'd0);
        chk("rst_upd_is_branch", upd_is_branch, 32'd0);
        chk("rst_upd_pc", upd_pc, 32'd0);
        chk("rst_redirect_valid", redirect_valid, 32'd0);
        chk("rst_redirect_pc", redirect_pc, 32'd0);
        chk("rst_resolve_err", resolve_err, 32'd0);
        chk("rst_branch_count", branch_count, 32'd0);
        chk("rst_mispredict_count", mispredict_count, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        push_valid = 1'b0; push_pc = '0; push_pred_taken = 1'b0; push_pred_target = '0;
        resolve_valid = 1'b0; resolve_taken = 1'b0; resolve_target = '0; flush = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check_reset_state();
        reset = 1'b0;

        // Correct not-taken
        push(32'h100, 1'b0, 32'h0);
        resolve(1'b0, 32'h0);
        idle();

        // Direction mispredict flushes the younger entry
        push(32'h200, 1'b0, 32'h0);
        push(32'h204, 1'b1, 32'h208);
        resolve(1'b1, 32'h400);
        idle();
        resolve(1'b0, 32'h0);
        idle();

        // Target mispredict, taken->not-taken, correct taken
        push(32'h300, 1'b1, 32'h500);
        resolve(1'b1, 32'h600);
        push(32'h310, 1'b1, 32'h500);
        resolve(1'b0, 32'h0);
        push(32'h320, 1'b1, 32'h700);
        resolve(1'b1, 32'h700);

        // Fill, refused push, in-order drain, then wrap
        for (int i = 0; i < 8; i++) push(32'h1000 + 32'(i * 4), 1'(i), 32'h2000 + 32'(i));
        push(32'hDEAD, 1'b0, 32'h0);
        for (int i = 0; i < 8; i++) resolve(1'(i), 32'h2000 + 32'(i));
        for (int i = 0; i < 3; i++) push(32'h3000 + 32'(i * 4), 1'b0, 32'h0);
        do_cycle(1'b1, 32'h4000, 1'b0, '0, 1'b1, 1'b0, '0, 1'b0);
        for (int i = 0; i < 3; i++) resolve(1'b0, 32'h0);
        idle();

        // Full queue refuses a push even while a resolve pops
        for (int i = 0; i < 8; i++) push(32'h5000 + 32'(i * 4), 1'b0, 32'h0);
        do_cycle(1'b1, 32'h6000, 1'b0, '0, 1'b1, 1'b0, '0, 1'b0);
        for (int i = 0; i < 7; i++) resolve(1'b0, 32'h0);
        resolve(1'b0, 32'h0);
        idle();

        // External flush variants
        for (int i = 0; i < 4; i++) push(32'h7000 + 32'(i * 4), 1'b0, 32'h0);
        do_cycle(1'b0, '0, 1'b0, '0, 1'b0, 1'b0, '0, 1'b1);
        idle();
        resolve(1'b0, 32'h0);
        push(32'h7100, 1'b0, 32'h0);
        push(32'h7104, 1'b0, 32'h0);
        do_cycle(1'b0, '0, 1'b0, '0, 1'b1, 1'b0, '0, 1'b1);
        resolve(1'b0, 32'h0);
        do_cycle(1'b1, 32'h7200, 1'b0, '0, 1'b0, 1'b0, '0, 1'b1);
        resolve(1'b0, 32'h0);

        // Mispredict drops the same-cycle push
        push(32'h7300, 1'b0, 32'h0);
        do_cycle(1'b1, 32'h7400, 1'b0, '0, 1'b1, 1'b1, 32'h7800, 1'b0);
        resolve(1'b0, 32'h0);
        idle();

        // Saturation of both counters
        for (int i = 0; i < 20; i++) begin
            push(32'h8000 + 32'(i * 4), 1'b0, 32'h0);
            resolve(1'b1, 32'h9000);
        end
        idle();
        chk("sat_branch_count", branch_count, 32'hF);
        chk("sat_mispredict_count", mispredict_count, 32'hF);

        // Reset mid-stream
        for (int i = 0; i < 3; i++) push(32'hA000 + 32'(i * 4), 1'b0, 32'h0);
        reset = 1'b1;
        push_valid = 1'b1;
        resolve_valid = 1'b1;
        model.delete();
        sb.delete();
        bc = 0;
        mc = 0;
        #1;
        chk("rst_mid_push_ready", push_ready, 32'd0);
        @(negedge clk);
        #1;
        check_reset_state();
        reset = 1'b0;
        resolve(1'b0, 32'h0);
        push(32'hB000, 1'b0, 32'h0);
        resolve(1'b0, 32'h0);
        idle();
        idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
